// File: rtl/interrupt_controller.sv
// Edge-triggered, fixed-priority interrupt controller: latches request edges and issues
// one interrupt pulse at a time, then blocks until pipeline drain and handler return complete.
module interrupt_controller #(
   parameter int NUM_IRQ      = 4,
   parameter int DRAIN_CYCLES = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_IRQ-1:0] irq,
   input  logic [NUM_IRQ-1:0] irq_mask,
   input  logic               int_done,
   input  logic               rti,
   output logic               interrupt,
   output logic [2:0]         irq_id,
   output logic [NUM_IRQ-1:0] pending,
   output logic               in_service
);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, SERVICE} state_t;

   state_t             state_reg, state_next;
   logic [NUM_IRQ-1:0] irq_q_reg;
   logic [NUM_IRQ-1:0] pending_reg, pending_next;
   logic [NUM_IRQ-1:0] edge_det, candidate, clear_mask;
   logic [3:0]         cnt_reg, cnt_next;
   logic               done_seen_reg, done_seen_next;
   logic               armed_reg;
   logic               interrupt_reg, interrupt_next;
   logic               in_service_reg, in_service_next;
   logic [2:0]         irq_id_reg, irq_id_next;
   logic [2:0]         winner;
   logic               issue_fire;

   // irq_q clears on reset, so the first post-reset sample only primes it; a line
   // held high through reset must toggle before it counts as a request.
   assign edge_det  = armed_reg ? (irq & ~irq_q_reg) : '0;
   assign candidate = pending_reg & ~irq_mask;

   always_comb begin
      winner = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (candidate[i]) winner = 3'(i);
      end
   end

   // A new edge on the line being issued wins over the clear.
   generate
      for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_pending
         assign clear_mask[gi]   = issue_fire && (winner == 3'(gi));
         assign pending_next[gi] = edge_det[gi] | (pending_reg[gi] & ~clear_mask[gi]);
      end
   endgenerate

   always_comb begin
      state_next      = state_reg;
      cnt_next        = cnt_reg;
      done_seen_next  = done_seen_reg;
      interrupt_next  = 1'b0;
      in_service_next = in_service_reg;
      irq_id_next     = irq_id_reg;
      issue_fire      = 1'b0;
      case (state_reg)
         IDLE: begin
            if (|candidate) begin
               issue_fire      = 1'b1;
               state_next      = ISSUE;
               interrupt_next  = 1'b1;
               irq_id_next     = winner;
               cnt_next        = 4'(DRAIN_CYCLES);
               in_service_next = 1'b1;
            end
         end
         ISSUE: state_next = DRAIN;
         DRAIN: begin
            if (int_done) done_seen_next = 1'b1;
            if (cnt_reg == 4'd0 && (done_seen_reg || int_done)) begin
               state_next = SERVICE;
            end else if (cnt_reg != 4'd0) begin
               cnt_next = cnt_reg - 4'd1;
            end
         end
         SERVICE: begin
            if (rti) begin
               state_next      = IDLE;
               done_seen_next  = 1'b0;
               in_service_next = 1'b0;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg      <= IDLE;
         irq_q_reg      <= '0;
         pending_reg    <= '0;
         cnt_reg        <= '0;
         done_seen_reg  <= 1'b0;
         armed_reg      <= 1'b0;
         interrupt_reg  <= 1'b0;
         in_service_reg <= 1'b0;
         irq_id_reg     <= '0;
      end else begin
         state_reg      <= state_next;
         irq_q_reg      <= irq;
         pending_reg    <= pending_next;
         cnt_reg        <= cnt_next;
         done_seen_reg  <= done_seen_next;
         armed_reg      <= 1'b1;
         interrupt_reg  <= interrupt_next;
         in_service_reg <= in_service_next;
         irq_id_reg     <= irq_id_next;
      end
   end

   assign interrupt  = interrupt_reg;
   assign irq_id     = irq_id_reg;
   assign pending    = pending_reg;
   assign in_service = in_service_reg;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: stimulus pushes expected irq_id values,
// a negedge monitor pops one per interrupt pulse; direct checks cover pending/in_service.
module tb_interrupt_controller;

   localparam int NUM_IRQ = 4;

   logic               clk = 1'b0;
   logic               reset;
   logic [NUM_IRQ-1:0] irq;
   logic [NUM_IRQ-1:0] irq_mask;
   logic               int_done;
   logic               rti;
   logic               interrupt;
   logic [2:0]         irq_id;
   logic [NUM_IRQ-1:0] pending;
   logic               in_service;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [2:0]  exp_q[$];
   logic        prev_int = 1'b0;

   interrupt_controller #(.NUM_IRQ(NUM_IRQ), .DRAIN_CYCLES(5)) dut (
      .clk       (clk),
      .reset     (reset),
      .irq       (irq),
      .irq_mask  (irq_mask),
      .int_done  (int_done),
      .rti       (rti),
      .interrupt (interrupt),
      .irq_id    (irq_id),
      .pending   (pending),
      .in_service(in_service)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: every interrupt pulse consumes one expected id.
   always @(negedge clk) begin
      if (reset) begin
         prev_int <= 1'b0;
      end else begin
         if (interrupt) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_interrupt: got irq_id %0d expected no interrupt at %0t", irq_id, $time);
            end else begin
               logic [2:0] e;
               e = exp_q.pop_front();
               if (irq_id !== e) begin
                  n_fail++;
                  $display("FAIL issue_id: got %0d expected %0d at %0t", irq_id, e, $time);
               end else begin
                  $display("issue irq_id=%0d at %0t", irq_id, $time);
               end
            end
            if (prev_int) begin
               n_fail++;
               $display("FAIL pulse_width: got 2 consecutive interrupt cycles expected 1 at %0t", $time);
            end
         end
         prev_int <= interrupt;
      end
   end

   // Called just after the issue edge; completes drain and handler return.
   task automatic svc();
      tick(1);
      int_done = 1'b1;
      tick(1);
      int_done = 1'b0;
      tick(5);
      rti = 1'b1;
      tick(1);
      rti = 1'b0;
      check("svc_return", in_service, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish before 200000");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; irq = '0; irq_mask = '0; int_done = 1'b0; rti = 1'b0;
      #3;
      check("rst_interrupt", interrupt, 0);
      check("rst_irq_id", irq_id, 0);
      check("rst_pending", pending, 0);
      check("rst_in_service", in_service, 0);
      tick(2);
      reset = 1'b0;
      tick(2);

      // Single request with early int_done and an rti arriving before SERVICE
      irq = 4'b0100; exp_q.push_back(3'd2);
      tick(1);
      check("s1_pending", pending, 4'b0100);
      check("s1_no_int_yet", interrupt, 0);
      tick(1);
      check("s1_interrupt", interrupt, 1);
      check("s1_irq_id", irq_id, 2);
      check("s1_pending_clr", pending, 0);
      check("s1_in_service", in_service, 1);
      tick(1);
      check("s1_int_drop", interrupt, 0);
      int_done = 1'b1;
      tick(1);
      int_done = 1'b0;
      tick(4);
      rti = 1'b1;
      tick(1);
      rti = 1'b0;
      check("s1_rti_in_drain_ignored", in_service, 1);
      tick(1);
      check("s1_service_hold", in_service, 1);
      rti = 1'b1;
      tick(1);
      rti = 1'b0;
      check("s1_return", in_service, 0);

      // Priority, no nesting
      irq = 4'b1110; exp_q.push_back(3'd1); exp_q.push_back(3'd3);
      tick(1);
      check("s2_pending_both", pending, 4'b1010);
      tick(1);
      check("s2_interrupt", interrupt, 1);
      check("s2_irq_id", irq_id, 1);
      check("s2_pending_left", pending, 4'b1000);
      tick(1);
      int_done = 1'b1;
      tick(1);
      int_done = 1'b0;
      tick(5);
      check("s2_pending_in_service", pending, 4'b1000);
      check("s2_in_service", in_service, 1);
      tick(2);
      check("s2_no_nesting", interrupt, 0);
      rti = 1'b1;
      tick(1);
      rti = 1'b0;
      check("s2_idle", in_service, 0);
      check("s2_idle_int", interrupt, 0);
      tick(1);
      check("s2_reissue", interrupt, 1);
      check("s2_reissue_id", irq_id, 3);
      check("s2_pending_empty", pending, 0);
      svc();

      // Masking
      irq = '0;
      tick(1);
      irq_mask = 4'b0001; irq = 4'b0001;
      tick(1);
      check("s3_pending_masked", pending, 4'b0001);
      tick(3);
      check("s3_no_int", interrupt, 0);
      check("s3_still_pending", pending, 4'b0001);
      irq_mask = '0; exp_q.push_back(3'd0);
      tick(1);
      check("s3_unmask_int", interrupt, 1);
      check("s3_unmask_id", irq_id, 0);
      svc();

      // Collision: new edge on the line being issued stays pending
      irq_mask = 4'b0100; irq = 4'b0100;
      tick(1);
      check("s4_pending_masked", pending, 4'b0100);
      irq = 4'b0000;
      tick(1);
      irq = 4'b0100; irq_mask = '0;
      exp_q.push_back(3'd2); exp_q.push_back(3'd2);
      tick(1);
      check("s4_interrupt", interrupt, 1);
      check("s4_irq_id", irq_id, 2);
      check("s4_pending_kept", pending, 4'b0100);
      svc();
      tick(1);
      check("s4_second_issue", interrupt, 1);
      check("s4_pending_clr", pending, 0);
      svc();

      // Asynchronous reset mid-DRAIN
      irq = 4'b0000;
      tick(1);
      irq = 4'b1010; exp_q.push_back(3'd1);
      tick(1);
      check("s5_pending", pending, 4'b1010);
      tick(1);
      check("s5_interrupt", interrupt, 1);
      tick(2);
      #2;
      reset = 1'b1;
      #1;
      check("s5_rst_interrupt", interrupt, 0);
      check("s5_rst_in_service", in_service, 0);
      check("s5_rst_pending", pending, 0);
      check("s5_rst_irq_id", irq_id, 0);
      tick(2);
      reset = 1'b0;
      tick(4);
      check("s5_held_no_pending", pending, 0);
      check("s5_held_no_service", in_service, 0);
      irq = 4'b0010;
      tick(1);
      irq = 4'b1010; exp_q.push_back(3'd3);
      tick(1);
      check("s5_toggle_pending", pending, 4'b1000);
      tick(1);
      check("s5_toggle_int", interrupt, 1);
      check("s5_toggle_id", irq_id, 3);
      svc();
      tick(3);

      check("scoreboard_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
